// File: rtl/tour_cmd_if.sv
// Signal bundle between tour_cmd, the tour solver, the UART wrapper and the command processor.
// master: the tour_cmd side. slave: the surrounding environment.
interface tour_cmd_if;
   logic        start_tour;
   logic [7:0]  move;
   logic [4:0]  mv_indx;
   logic [15:0] cmd_UART;
   logic        cmd_rdy_UART;
   logic        clr_cmd_rdy_UART;
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy;
   logic        send_resp;
   logic [7:0]  resp;

   modport master (
      input  start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
      output mv_indx, clr_cmd_rdy_UART, cmd, cmd_rdy, resp
   );

   modport slave (
      output start_tour, move, cmd_UART, cmd_rdy_UART, clr_cmd_rdy, send_resp,
      input  mv_indx, clr_cmd_rdy_UART, cmd, cmd_rdy, resp
   );
endinterface

// File: rtl/tour_cmd.sv
// Replays a solved 24-move knight's tour as vertical/horizontal motion commands,
// muxing them in front of the UART command path while the tour runs.
module tour_cmd (
   input logic        clk,
   input logic        rst_n,
   tour_cmd_if.master bus
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] VERT   = 3'd1;
   localparam logic [2:0] HOLD_V = 3'd2;
   localparam logic [2:0] HORZ   = 3'd3;
   localparam logic [2:0] HOLD_H = 3'd4;

   localparam logic [7:0] HDG_N = 8'h00;
   localparam logic [7:0] HDG_W = 8'h3F;
   localparam logic [7:0] HDG_S = 8'h7F;
   localparam logic [7:0] HDG_E = 8'hBF;

   logic [2:0]  state_q, state_d;
   logic [4:0]  mv_indx_q, mv_indx_d;
   logic [15:0] vert_cmd, horz_cmd;
   logic        last_move;

   assign last_move   = (mv_indx_q == 5'd23);
   assign bus.mv_indx = mv_indx_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         mv_indx_q <= 5'd0;
      end else begin
         state_q   <= state_d;
         mv_indx_q <= mv_indx_d;
      end
   end

   // send_resp only counts in the HOLD states, so a late response can never skip a leg.
   always_comb begin
      state_d   = state_q;
      mv_indx_d = mv_indx_q;
      case (state_q)
         IDLE: begin
            if (bus.start_tour) begin
               state_d   = VERT;
               mv_indx_d = 5'd0;
            end
         end
         VERT:   if (bus.clr_cmd_rdy) state_d = HOLD_V;
         HOLD_V: if (bus.send_resp)   state_d = HORZ;
         HORZ:   if (bus.clr_cmd_rdy) state_d = HOLD_H;
         HOLD_H: begin
            if (bus.send_resp) begin
               if (last_move) begin
                  state_d = IDLE;
               end else begin
                  state_d   = VERT;
                  mv_indx_d = mv_indx_q + 5'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // One-hot move -> two legs; anything not one-hot gives zero-length legs.
   always_comb begin
      vert_cmd = {4'b0010, HDG_N, 4'd0};
      horz_cmd = {4'b0011, HDG_N, 4'd0};
      case (bus.move)
         8'h01: begin vert_cmd = {4'b0010, HDG_N, 4'd2}; horz_cmd = {4'b0011, HDG_E, 4'd1}; end
         8'h02: begin vert_cmd = {4'b0010, HDG_N, 4'd2}; horz_cmd = {4'b0011, HDG_W, 4'd1}; end
         8'h04: begin vert_cmd = {4'b0010, HDG_N, 4'd1}; horz_cmd = {4'b0011, HDG_W, 4'd2}; end
         8'h08: begin vert_cmd = {4'b0010, HDG_S, 4'd1}; horz_cmd = {4'b0011, HDG_W, 4'd2}; end
         8'h10: begin vert_cmd = {4'b0010, HDG_S, 4'd2}; horz_cmd = {4'b0011, HDG_W, 4'd1}; end
         8'h20: begin vert_cmd = {4'b0010, HDG_S, 4'd2}; horz_cmd = {4'b0011, HDG_E, 4'd1}; end
         8'h40: begin vert_cmd = {4'b0010, HDG_S, 4'd1}; horz_cmd = {4'b0011, HDG_E, 4'd2}; end
         8'h80: begin vert_cmd = {4'b0010, HDG_N, 4'd1}; horz_cmd = {4'b0011, HDG_E, 4'd2}; end
         default: ;
      endcase
   end

   always_comb begin
      bus.cmd              = bus.cmd_UART;
      bus.cmd_rdy          = bus.cmd_rdy_UART;
      bus.clr_cmd_rdy_UART = bus.clr_cmd_rdy;
      bus.resp             = 8'h5A;
      case (state_q)
         IDLE:   bus.resp = 8'hA5;
         VERT:   begin bus.cmd = vert_cmd; bus.cmd_rdy = 1'b1; bus.clr_cmd_rdy_UART = 1'b0; end
         HOLD_V: begin bus.cmd = vert_cmd; bus.cmd_rdy = 1'b0; bus.clr_cmd_rdy_UART = 1'b0; end
         HORZ:   begin bus.cmd = horz_cmd; bus.cmd_rdy = 1'b1; bus.clr_cmd_rdy_UART = 1'b0; end
         HOLD_H: begin
            bus.cmd              = horz_cmd;
            bus.cmd_rdy          = 1'b0;
            bus.clr_cmd_rdy_UART = 1'b0;
            if (last_move) bus.resp = 8'hA5;
         end
         default: begin bus.cmd_rdy = 1'b0; bus.clr_cmd_rdy_UART = 1'b0; end
      endcase
   end

endmodule

// File: tb/tb_tour_cmd.sv
// Scoreboard bench for tour_cmd: expected commands are queued when a tour is started
// and popped as the DUT presents each command.
module tb_tour_cmd;

   logic clk;
   logic rst_n;
   tour_cmd_if bus ();

   tour_cmd dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   logic [7:0] tour_moves [24];
   logic [15:0] sb [$];
   int checks   = 0;
   int failures = 0;

   // The solver is modelled as a memory read at the index the DUT drives.
   assign bus.move = (bus.mv_indx < 5'd24) ? tour_moves[bus.mv_indx] : 8'h00;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   function automatic logic [15:0] model_cmd(input logic [7:0] mv, input bit is_h);
      int dx, dy;
      bit ok;
      logic [7:0] hdg;
      logic [3:0] sq;
      ok = 1'b1;
      dx = 0;
      dy = 0;
      case (mv)
         8'h01: begin dx =  1; dy =  2; end
         8'h02: begin dx = -1; dy =  2; end
         8'h04: begin dx = -2; dy =  1; end
         8'h08: begin dx = -2; dy = -1; end
         8'h10: begin dx = -1; dy = -2; end
         8'h20: begin dx =  1; dy = -2; end
         8'h40: begin dx =  2; dy = -1; end
         8'h80: begin dx =  2; dy =  1; end
         default: ok = 1'b0;
      endcase
      if (!ok) begin
         hdg = 8'h00;
         sq  = 4'd0;
      end else if (is_h) begin
         hdg = (dx > 0) ? 8'hBF : 8'h3F;
         sq  = 4'((dx > 0) ? dx : -dx);
      end else begin
         hdg = (dy > 0) ? 8'h00 : 8'h7F;
         sq  = 4'((dy > 0) ? dy : -dy);
      end
      return {(is_h ? 4'b0011 : 4'b0010), hdg, sq};
   endfunction

   task automatic push_tour();
      for (int i = 0; i < 24; i++) begin
         sb.push_back(model_cmd(tour_moves[i], 1'b0));
         sb.push_back(model_cmd(tour_moves[i], 1'b1));
      end
   endtask

   // Serve one command: wait for cmd_rdy, compare, ack, then respond (unless stop_in_hold).
   task automatic serve_cmd(input int m, input bit is_h, input bit quirk_ign,
                            input bit quirk_simul, input bit stop_in_hold);
      logic [15:0] e;
      int waited;
      waited = 0;
      settle();
      while (!bus.cmd_rdy && waited < 20) begin
         tick();
         settle();
         waited++;
      end
      chk("cmd_rdy_wait", 32'(bus.cmd_rdy), 32'd1);
      e = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
      chk(is_h ? "cmd_horz" : "cmd_vert", 32'(bus.cmd), 32'(e));
      chk("mv_indx", 32'(bus.mv_indx), 32'(m));
      chk("resp_busy", 32'(bus.resp), 32'h5A);
      $display("cmd m=%0d %s cmd=%04h exp=%04h", m, is_h ? "H" : "V", bus.cmd, e);
      if (quirk_ign) begin
         bus.send_resp = 1'b1;
         tick();
         bus.send_resp = 1'b0;
         settle();
         chk("send_resp_ignored_rdy", 32'(bus.cmd_rdy), 32'd1);
         chk("send_resp_ignored_cmd", 32'(bus.cmd), 32'(e));
      end
      bus.clr_cmd_rdy = 1'b1;
      if (quirk_simul) bus.send_resp = 1'b1;
      settle();
      chk("clr_uart_masked", 32'(bus.clr_cmd_rdy_UART), 32'd0);
      tick();
      bus.clr_cmd_rdy = 1'b0;
      bus.send_resp   = 1'b0;
      settle();
      chk("rdy_drop", 32'(bus.cmd_rdy), 32'd0);
      chk("hold_cmd", 32'(bus.cmd), 32'(e));
      if (quirk_simul) begin
         tick();
         settle();
         chk("simul_stays_hold", 32'(bus.cmd_rdy), 32'd0);
      end
      chk("resp_hold", 32'(bus.resp), (is_h && m == 23) ? 32'hA5 : 32'h5A);
      if (!stop_in_hold) begin
         bus.send_resp = 1'b1;
         tick();
         bus.send_resp = 1'b0;
      end
   endtask

   initial begin
      for (int i = 0; i < 24; i++) tour_moves[i] = 8'h01 << ((i * 3) % 8);
      tour_moves[0] = 8'h01;
      tour_moves[1] = 8'h08;
      tour_moves[2] = 8'h10;
      tour_moves[3] = 8'h40;
      tour_moves[4] = 8'h80;
      tour_moves[5] = 8'h00;
      tour_moves[6] = 8'h24;

      rst_n            = 1'b0;
      bus.start_tour   = 1'b0;
      bus.cmd_UART     = 16'h1234;
      bus.cmd_rdy_UART = 1'b1;
      bus.clr_cmd_rdy  = 1'b0;
      bus.send_resp    = 1'b0;
      tick();
      settle();
      chk("reset_mv_indx", 32'(bus.mv_indx), 32'd0);
      chk("reset_resp", 32'(bus.resp), 32'hA5);
      rst_n = 1'b1;
      tick();
      settle();
      chk("pass_cmd", 32'(bus.cmd), 32'h1234);
      chk("pass_rdy", 32'(bus.cmd_rdy), 32'd1);
      chk("idle_resp", 32'(bus.resp), 32'hA5);
      bus.clr_cmd_rdy = 1'b1;
      settle();
      chk("pass_clr", 32'(bus.clr_cmd_rdy_UART), 32'd1);
      bus.clr_cmd_rdy = 1'b0;
      settle();
      chk("pass_clr_low", 32'(bus.clr_cmd_rdy_UART), 32'd0);

      // Full tour with a pending UART command that must stay masked.
      bus.cmd_UART     = 16'hDEAD;
      bus.cmd_rdy_UART = 1'b1;
      tick();
      bus.start_tour = 1'b1;
      push_tour();
      tick();
      bus.start_tour = 1'b0;
      settle();
      chk("first_rdy", 32'(bus.cmd_rdy), 32'd1);
      chk("first_cmd", 32'(bus.cmd), 32'h2002);
      for (int m = 0; m < 24; m++) begin
         if (m == 10) begin
            bus.start_tour = 1'b1;
            tick();
            bus.start_tour = 1'b0;
            settle();
            chk("restart_ignored", 32'(bus.mv_indx), 32'd10);
         end
         serve_cmd(m, 1'b0, m == 1, 1'b0, 1'b0);
         serve_cmd(m, 1'b1, 1'b0, m == 2, 1'b0);
      end
      settle();
      chk("end_idle_resp", 32'(bus.resp), 32'hA5);
      chk("end_pass_cmd", 32'(bus.cmd), 32'hDEAD);
      chk("end_pass_rdy", 32'(bus.cmd_rdy), 32'd1);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      // Second tour, reset while holding the vertical leg of move 7.
      bus.cmd_rdy_UART = 1'b0;
      tick();
      bus.start_tour = 1'b1;
      push_tour();
      tick();
      bus.start_tour = 1'b0;
      for (int m = 0; m < 7; m++) begin
         serve_cmd(m, 1'b0, 1'b0, 1'b0, 1'b0);
         serve_cmd(m, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      serve_cmd(7, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("pre_reset_idx", 32'(bus.mv_indx), 32'd7);
      bus.cmd_rdy_UART = 1'b1;
      rst_n = 1'b0;
      settle();
      chk("rst_mv_indx", 32'(bus.mv_indx), 32'd0);
      chk("rst_pass_cmd", 32'(bus.cmd), 32'hDEAD);
      chk("rst_pass_rdy", 32'(bus.cmd_rdy), 32'd1);
      sb.delete();
      tick();
      rst_n = 1'b1;
      bus.cmd_rdy_UART = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         settle();
         chk("no_replay_rdy", 32'(bus.cmd_rdy), 32'd0);
         chk("no_replay_idx", 32'(bus.mv_indx), 32'd0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tour_cmd.md
# tour_cmd

Downstream consumer of the knight's-tour solver. Once a 24-move solution is complete, this block walks the stored moves by driving the solver's read index. It expands each one-hot knight move into two motion commands: a vertical leg, then a horizontal leg with fanfare. It presents these to the command processor in place of UART commands, so the robot physically executes the tour.

## Interface

Parameters: none; the 5x5 board and 24-move tour length are fixed.

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  reset, asynchronous, active-low
- start_tour  in  1  one-cycle pulse from the solver: solution complete
- move  in  8  one-hot move read back from the solver at index mv_indx
- mv_indx  out  5  index of the move being executed (0..23)
- cmd_UART  in  16  command from the UART wrapper
- cmd_rdy_UART  in  1  UART command valid
- clr_cmd_rdy_UART  out  1  acknowledge to the UART wrapper
- cmd  out  16  command to the command processor
- cmd_rdy  out  1  cmd valid
- clr_cmd_rdy  in  1  command processor has consumed cmd
- send_resp  in  1  command processor finished executing cmd
- resp  out  8  response byte for the UART

## Operation

**Command format**
- cmd[15:12] opcode: 4'b0010 is a plain move; 4'b0011 is a move with fanfare.
- cmd[11:4] heading: N=8'h00, W=8'h3F, S=8'h7F, E=8'hBF.
- cmd[3:0] squares.

**Move decode** (+y = North, +x = East), written as move: (dx,dy):
- bit0: (+1,+2)
- bit1: (-1,+2)
- bit2: (-2,+1)
- bit3: (-2,-1)
- bit4: (-1,-2)
- bit5: (+1,-2)
- bit6: (+2,-1)
- bit7: (+2,+1)

**Commands per move**
- Vertical command: opcode 4'b0010, heading N if dy>0 else S, squares |dy|.
- Horizontal command: opcode 4'b0011, heading E if dx>0 else W, squares |dx|.
- Non-one-hot move (zero or multi-hot): both commands are still issued, with heading 8'h00 and squares 0.

**State machine**
- IDLE: mux passes UART through: cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy. On start_tour: mv_indx<=0, go to VERT.
- VERT: cmd=vertical command, cmd_rdy=1. On clr_cmd_rdy, go to HOLD_V.
- HOLD_V: cmd_rdy=0, cmd holds its value. On send_resp, go to HORZ.
- HORZ: cmd=horizontal command, cmd_rdy=1. On clr_cmd_rdy, go to HOLD_H.
- HOLD_H: cmd_rdy=0. On send_resp:
  - if mv_indx==23, go to IDLE;
  - else mv_indx<=mv_indx+1, go to VERT.

**Outside IDLE**
- cmd_rdy_UART is masked and clr_cmd_rdy_UART is held at 0, so a pending UART command stays pending until the tour ends.
- start_tour is ignored.

**Response**
- resp=8'hA5 in IDLE, and in HOLD_H when mv_indx==23.
- Otherwise resp=8'h5A.

## Timing

- Reset values: state IDLE, mv_indx=0, cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy, resp=8'hA5.
- mv_indx is registered. move is decoded combinationally from mv_indx, and mv_indx is constant across both commands of a move.
- cmd, cmd_rdy and resp are combinational functions of state, move, mv_indx and the UART inputs.
- First tour cmd_rdy=1 appears in the cycle after start_tour is sampled.
- After clr_cmd_rdy is sampled, cmd_rdy is 0 from the next cycle.
- Simultaneous clr_cmd_rdy and send_resp in VERT or HORZ: only clr_cmd_rdy is acted on. send_resp is honoured only in the HOLD states.
- send_resp in VERT or HORZ is ignored.
- Full tour: exactly 48 commands, then return to IDLE in the cycle after the 48th send_resp.
- rst_n asserted mid-tour: immediate return to IDLE and mv_indx=0. No command is replayed after reset.

## Test plan

1. Reset, then cmd_UART=16'h1234 with cmd_rdy_UART=1 -> cmd=16'h1234, cmd_rdy=1, resp=8'hA5. Pulse clr_cmd_rdy -> clr_cmd_rdy_UART=1 in the same cycle.
2. start_tour with move=8'h01 -> next cycle cmd=16'h2002, cmd_rdy=1. Then clr_cmd_rdy, then send_resp -> cmd=16'h3BF1.
3. Moves 8'h08 -> 16'h27F1 then 16'h33F2. Move 8'h10 -> 16'h27F2 then 16'h33F1. Move 8'h40 -> 16'h27F1 then 16'h3BF2. Move 8'h80 -> 16'h2001 then 16'h3BF2.
4. Full 24-move tour with a bench that auto-acks -> 48 commands, mv_indx steps 0..23, resp=8'h5A until the final HOLD_H, then 8'hA5, then IDLE.
5. cmd_rdy_UART=1 during a tour -> clr_cmd_rdy_UART stays 0 and cmd never shows cmd_UART. A second start_tour mid-tour does not change mv_indx.
6. rst_n pulsed in HOLD_V at mv_indx=7 -> mv_indx=0, passthrough restored, and cmd_rdy follows cmd_rdy_UART.
